shift_reg_cnt_gen: RTL and testbench
====================================

Name: shift_reg_cnt_gen

Overview:
Parametrised serial-in shift register with a running ones-counter and a pattern-match event counter; this is the next generation of the 4-stage serial shift register.
- Adds configurable depth, bidirectional shift, hold and parallel load.
- Keeps an incrementally maintained population count of the register contents.
- Detects a programmable bit pattern and counts matches with saturation.
- Sits between a serial data source and control/status logic that needs both the window bits and summary statistics.

Parameters:
DEPTH, 4, number of register stages (≥2)
CNT_W, 8, width of the match event counter
CW, $clog2(DEPTH+1), width of the ones count (derived, not overridable)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
in  input  1  serial data bit
mode  input  2  00 HOLD, 01 SHL (in enters bit 0), 10 SHR (in enters bit DEPTH-1), 11 LOAD
load_data  input  DEPTH  parallel value used in LOAD
pattern  input  DEPTH  compare value for match detection
match_clr  input  1  clears the match counter
q  output  DEPTH  register contents; q[0] is the newest bit in SHL
result  output  1  serial out: q[DEPTH-1] in SHL, q[0] in SHR, 0 otherwise
ones_cnt  output  CW  number of 1s in q, registered, always consistent with q
match  output  1  one-cycle pulse: registered q equals pattern
match_cnt  output  CNT_W  saturating count of match pulses

Behaviour:
- Reset (rst=1 at the edge):
  - q, ones_cnt, match and match_cnt all go to 0.
  - rst has priority over every other input.
- HOLD: q is unchanged and ones_cnt is unchanged.
- SHL:
  - q <= {q[DEPTH-2:0], in}.
  - ones_cnt <= ones_cnt + in - q[DEPTH-1] (the bit shifted out).
- SHR:
  - q <= {in, q[DEPTH-1:1]}.
  - ones_cnt <= ones_cnt + in - q[0].
- LOAD:
  - q <= load_data.
  - ones_cnt <= popcount(load_data).
- ones_cnt is never recomputed from q outside LOAD; the incremental update must equal popcount(q) on every cycle. Verification checks this invariant.
- result is combinational from the registered q and the current mode.
- Latency: q and ones_cnt reflect the inputs of edge N immediately after edge N.
- match:
  - Registered: match <= (q_next == pattern), so it asserts in the same cycle the matching q appears.
  - It pulses on every cycle the condition holds, including a HOLD with a matching q, which pulses every cycle.
  - It is 0 during and after reset until a real update produces a match; q==0 with pattern==0 right after reset does not pulse until the first non-reset edge.
- match_cnt:
  - Increments by 1 on each edge where match_next=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - match_clr forces match_cnt to 0 at the edge.
  - If match_clr and a match occur at the same edge, the result is 0: clear wins, and the match pulse itself is still emitted.
- pattern and mode changes take effect at the next edge; pattern is not registered internally.
- Boundary cases:
  - SHL/SHR where the in bit equals the outgoing bit leaves ones_cnt unchanged.
  - ones_cnt stays within 0..DEPTH.
  - Reset mid-stream discards all contents with no residual pulse.

Decomposition:
- Package shift_reg_cnt_pkg:
  - mode localparams MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_LOAD=2'b11.
  - popcount function.
- One sub-module, popcount_comb: parametrised combinational popcount of a DEPTH-bit vector. Used for LOAD and as the reference in assertions.
- Main module holds the q register, the incremental counter, match logic and the saturating counter.

Test Plan:
1. Reset then SHL with in=1,1,0,1 (DEPTH=4, from reset 0) -> q=0001,0011,0110,1101; ones_cnt=1,2,2,3; result=0,0,0,1.
2. LOAD 1010, then SHR with in=1 twice -> q=1010,1101,1110; ones_cnt=2,3,3; result in SHR = q[0] = 0,1,0.
3. pattern=0110, SHL stream 0,1,1,0 from q=0 -> match pulses once, on the 4th edge; match_cnt=1; then HOLD 3 cycles -> match high each cycle, match_cnt=4.
4. CNT_W=2 with 5 consecutive matches -> match_cnt=1,2,3,3,3 (saturates); then match_clr together with a match -> match_cnt=0 and match=1.
5. Assert rst mid-stream with q=1111 -> next edge q=0000, ones_cnt=0, match=0, match_cnt=0; shifting resumes from zero.
6. Random mode/in/load_data over 10k cycles (DEPTH=4, 7, 16) -> ones_cnt == popcount(q) every cycle; q matches a golden model.

Source files
------------

// File: rtl/shift_reg_cnt_pkg.sv
// Shared definitions for the shift register with ones/match counters:
// shift-mode encodings and a reference population count.
package shift_reg_cnt_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Widest vector the popcount helper accepts; narrower vectors are zero-extended.
    localparam int POP_MAX_W = 64;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/popcount_comb.sv
// Combinational count of set bits in a DEPTH-bit vector (DEPTH <= POP_MAX_W).
module popcount_comb
    import shift_reg_cnt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]             i_vec,
    output logic [$clog2(DEPTH+1)-1:0]   o_cnt
);

    localparam int CW = $clog2(DEPTH + 1);

    always_comb begin
        o_cnt = CW'(popcount(POP_MAX_W'(i_vec)));
    end

endmodule

// File: rtl/shift_reg_cnt_gen.sv
// Bidirectional shift register with load/hold, an incrementally maintained
// ones count, and a saturating counter of cycles where q equals pattern.
module shift_reg_cnt_gen
    import shift_reg_cnt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in,
    input  logic [1:0]                   mode,
    input  logic [DEPTH-1:0]             load_data,
    input  logic [DEPTH-1:0]             pattern,
    input  logic                         match_clr,
    output logic [DEPTH-1:0]             q,
    output logic                         result,
    output logic [$clog2(DEPTH+1)-1:0]   ones_cnt,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_q;
    logic [CW-1:0]    r_ones;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt;

    logic [DEPTH-1:0] w_q_next;
    logic [CW-1:0]    w_ones_next;
    logic [CW-1:0]    w_pop_load;
    logic [CW-1:0]    w_pop_q;
    logic             w_match_next;

    popcount_comb #(.DEPTH(DEPTH)) u_pop_load (
        .i_vec (load_data),
        .o_cnt (w_pop_load)
    );

    popcount_comb #(.DEPTH(DEPTH)) u_pop_q (
        .i_vec (r_q),
        .o_cnt (w_pop_q)
    );

    // The count tracks only the bit entering and the bit leaving; a full
    // recount happens solely on a parallel load.
    always_comb begin
        w_q_next    = r_q;
        w_ones_next = r_ones;
        case (mode)
            MODE_SHL: begin
                w_q_next    = {r_q[DEPTH-2:0], in};
                w_ones_next = r_ones + CW'(in) - CW'(r_q[DEPTH-1]);
            end
            MODE_SHR: begin
                w_q_next    = {in, r_q[DEPTH-1:1]};
                w_ones_next = r_ones + CW'(in) - CW'(r_q[0]);
            end
            MODE_LOAD: begin
                w_q_next    = load_data;
                w_ones_next = w_pop_load;
            end
            default: ;
        endcase
        w_match_next = (w_q_next == pattern);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= '0;
            r_ones  <= '0;
            r_match <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_q     <= w_q_next;
            r_ones  <= w_ones_next;
            r_match <= w_match_next;
            // Clear beats a simultaneous match; the pulse itself still fires.
            if (match_clr) begin
                r_cnt <= '0;
            end else if (w_match_next && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        case (mode)
            MODE_SHL: result = r_q[DEPTH-1];
            MODE_SHR: result = r_q[0];
            default:  result = 1'b0;
        endcase
    end

    assign q         = r_q;
    assign ones_cnt  = r_ones;
    assign match     = r_match;
    assign match_cnt = r_cnt;

    a_ones_consistent: assert property (@(posedge clk) disable iff (rst) r_ones == w_pop_q);
    a_ones_bounded:    assert property (@(posedge clk) disable iff (rst) r_ones <= CW'(DEPTH));

endmodule

// File: tb/tb_shift_reg_cnt_gen.sv
// Bench for shift_reg_cnt_gen: four instances (DEPTH 4 / CNT_W 8, DEPTH 4 / CNT_W 2,
// DEPTH 7, DEPTH 16) share mode/in/rst/clr and are checked against a behavioural model.
module tb_shift_reg_cnt_gen;
    import shift_reg_cnt_pkg::*;

    localparam int D [3] = '{4, 7, 16};

    logic        clk;
    logic        rst;
    logic        in_b;
    logic [1:0]  mode;
    logic [15:0] ld16;
    logic        clr;
    logic [15:0] pat [3];

    logic [3:0]  q4,  q4s;
    logic [2:0]  ones4, ones4s;
    logic        res4, res4s, match4, match4s;
    logic [7:0]  cnt4;
    logic [1:0]  cnt4s;
    logic [6:0]  q7;
    logic [2:0]  ones7;
    logic        res7, match7;
    logic [7:0]  cnt7;
    logic [15:0] q16;
    logic [4:0]  ones16;
    logic        res16, match16;
    logic [7:0]  cnt16;

    logic [15:0] m_q [3];
    logic        m_match [3];
    int          m_cnt [3];
    int          m_cnt2;

    logic [27:0] exp_q [$];
    logic [50:0] exp_w_q [$];

    int checks;
    int fails;

    shift_reg_cnt_gen #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in(in_b), .mode(mode), .load_data(ld16[3:0]),
        .pattern(pat[0][3:0]), .match_clr(clr), .q(q4), .result(res4),
        .ones_cnt(ones4), .match(match4), .match_cnt(cnt4)
    );

    shift_reg_cnt_gen #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in(in_b), .mode(mode), .load_data(ld16[3:0]),
        .pattern(pat[0][3:0]), .match_clr(clr), .q(q4s), .result(res4s),
        .ones_cnt(ones4s), .match(match4s), .match_cnt(cnt4s)
    );

    shift_reg_cnt_gen #(.DEPTH(7), .CNT_W(8)) dut7 (
        .clk(clk), .rst(rst), .in(in_b), .mode(mode), .load_data(ld16[6:0]),
        .pattern(pat[1][6:0]), .match_clr(clr), .q(q7), .result(res7),
        .ones_cnt(ones7), .match(match7), .match_cnt(cnt7)
    );

    shift_reg_cnt_gen #(.DEPTH(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst), .in(in_b), .mode(mode), .load_data(ld16),
        .pattern(pat[2]), .match_clr(clr), .q(q16), .result(res16),
        .ones_cnt(ones16), .match(match16), .match_cnt(cnt16)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic logic [15:0] msk(input int d);
        return 16'((32'd1 << d) - 32'd1);
    endfunction

    function automatic int pc(input logic [15:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 16; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [15:0] next_q(input logic [15:0] cur, input int d,
                                           input logic [1:0] md, input logic b,
                                           input logic [15:0] ld);
        case (md)
            MODE_SHL:  return ((cur << 1) | 16'(b)) & msk(d);
            MODE_SHR:  return (cur >> 1) | (16'(b) << (d - 1));
            MODE_LOAD: return ld & msk(d);
            default:   return cur;
        endcase
    endfunction

    function automatic logic res_of(input logic [15:0] cur, input int d, input logic [1:0] md);
        if (md == MODE_SHL) return cur[d-1];
        if (md == MODE_SHR) return cur[0];
        return 1'b0;
    endfunction

    function automatic logic [27:0] obs_n();
        return {q4, ones4, res4, match4, cnt4, q4s, ones4s, res4s, match4s, cnt4s};
    endfunction

    function automatic logic [50:0] obs_w();
        return {q7, ones7, res7, match7, cnt7, q16, ones16, res16, match16, cnt16};
    endfunction

    // ---------------- driver ----------------
    // Applies one cycle of inputs, pushes the model's post-edge outputs, then
    // advances to just after the edge.
    task automatic drive(input logic [1:0] md, input logic b, input logic [15:0] ld,
                         input logic c, input logic r);
        logic [15:0] nq;
        mode = md; in_b = b; ld16 = ld; clr = c; rst = r;
        for (int k = 0; k < 3; k++) begin
            nq = r ? 16'h0 : next_q(m_q[k], D[k], md, b, ld);
            m_match[k] = !r && (nq == (pat[k] & msk(D[k])));
            if (r || c) m_cnt[k] = 0;
            else if (m_match[k] && m_cnt[k] < 255) m_cnt[k]++;
            m_q[k] = nq;
        end
        if (r || c) m_cnt2 = 0;
        else if (m_match[0] && m_cnt2 < 3) m_cnt2++;
        exp_q.push_back({m_q[0][3:0], 3'(pc(m_q[0])), res_of(m_q[0], 4, md), m_match[0],
                         8'(m_cnt[0]), m_q[0][3:0], 3'(pc(m_q[0])), res_of(m_q[0], 4, md),
                         m_match[0], 2'(m_cnt2)});
        exp_w_q.push_back({m_q[1][6:0], 3'(pc(m_q[1])), res_of(m_q[1], 7, md), m_match[1],
                           8'(m_cnt[1]), m_q[2], 5'(pc(m_q[2])), res_of(m_q[2], 16, md),
                           m_match[2], 8'(m_cnt[2])});
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [27:0] e4;
        logic [50:0] ew;
        logic [1:0]  rs [4] = '{1, 1, 0, 1};
        pat[0] = 16'h0; pat[1] = 16'h0; pat[2] = 16'h0;
        for (int i = 0; i < 4; i++) begin
            drive(MODE_HOLD, 1'b0, 16'h0, 1'b0, rs[i][0]);
            e4 = exp_q.pop_front(); ew = exp_w_q.pop_front();
            checks += 3;
            if (obs_n() !== e4) begin fails++; $display("FAIL reset_sb4 step %0d: got %h, required %h", i, obs_n(), e4); end
            if (obs_w() !== ew) begin fails++; $display("FAIL reset_sbw step %0d: got %h, required %h", i, obs_w(), ew); end
            // Zero pattern pulses only on the first non-reset edge.
            if (match4 !== !rs[i][0]) begin fails++; $display("FAIL reset_match step %0d: got %b, required %b", i, match4, !rs[i][0]); end
        end
        checks += 3;
        if (q4 !== 4'h0)    begin fails++; $display("FAIL reset_q: got %h, required 0", q4); end
        if (ones4 !== 3'd0) begin fails++; $display("FAIL reset_ones: got %0d, required 0", ones4); end
        if (cnt4 !== 8'd0)  begin fails++; $display("FAIL reset_cnt: got %0d, required 0", cnt4); end
    endtask

    task automatic test_shl();
        logic [27:0] e4;
        logic [50:0] ew;
        logic       b  [4] = '{1, 1, 0, 1};
        logic [3:0] eq [4] = '{4'b0001, 4'b0011, 4'b0110, 4'b1101};
        logic [2:0] eo [4] = '{3'd1, 3'd2, 3'd2, 3'd3};
        logic       er [4] = '{0, 0, 0, 1};
        pat[0] = 16'h000F; pat[1] = 16'h007F; pat[2] = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            drive(MODE_SHL, b[i], 16'h0, 1'b0, 1'b0);
            e4 = exp_q.pop_front(); ew = exp_w_q.pop_front();
            checks += 5;
            if (obs_n() !== e4) begin fails++; $display("FAIL shl_sb4 step %0d: got %h, required %h", i, obs_n(), e4); end
            if (obs_w() !== ew) begin fails++; $display("FAIL shl_sbw step %0d: got %h, required %h", i, obs_w(), ew); end
            if (q4 !== eq[i])    begin fails++; $display("FAIL shl_q step %0d: got %b, required %b", i, q4, eq[i]); end
            if (ones4 !== eo[i]) begin fails++; $display("FAIL shl_ones step %0d: got %0d, required %0d", i, ones4, eo[i]); end
            if (res4 !== er[i])  begin fails++; $display("FAIL shl_result step %0d: got %b, required %b", i, res4, er[i]); end
        end
    endtask

    task automatic test_load_shr();
        logic [27:0] e4;
        logic [50:0] ew;
        logic [1:0] md [3] = '{MODE_LOAD, MODE_SHR, MODE_SHR};
        logic [3:0] eq [3] = '{4'b1010, 4'b1101, 4'b1110};
        logic [2:0] eo [3] = '{3'd2, 3'd3, 3'd3};
        logic       er [3] = '{0, 1, 0};
        for (int i = 0; i < 3; i++) begin
            drive(md[i], 1'b1, 16'hC35A, 1'b0, 1'b0);
            e4 = exp_q.pop_front(); ew = exp_w_q.pop_front();
            checks += 5;
            if (obs_n() !== e4) begin fails++; $display("FAIL load_shr_sb4 step %0d: got %h, required %h", i, obs_n(), e4); end
            if (obs_w() !== ew) begin fails++; $display("FAIL load_shr_sbw step %0d: got %h, required %h", i, obs_w(), ew); end
            if (q4 !== eq[i])    begin fails++; $display("FAIL load_shr_q step %0d: got %b, required %b", i, q4, eq[i]); end
            if (ones4 !== eo[i]) begin fails++; $display("FAIL load_shr_ones step %0d: got %0d, required %0d", i, ones4, eo[i]); end
            if (res4 !== er[i])  begin fails++; $display("FAIL load_shr_result step %0d: got %b, required %b", i, res4, er[i]); end
        end
    endtask

    task automatic test_match();
        logic [27:0] e4;
        logic [50:0] ew;
        logic [1:0] md [7] = '{MODE_SHL, MODE_SHL, MODE_SHL, MODE_SHL, MODE_HOLD, MODE_HOLD, MODE_HOLD};
        logic       b  [7] = '{0, 1, 1, 0, 0, 0, 0};
        logic       em [7] = '{0, 0, 0, 1, 1, 1, 1};
        logic [7:0] ec [7] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        drive(MODE_HOLD, 1'b0, 16'h0, 1'b0, 1'b1);
        void'(exp_q.pop_front()); void'(exp_w_q.pop_front());
        pat[0] = 16'h0006;
        for (int i = 0; i < 7; i++) begin
            drive(md[i], b[i], 16'h0, 1'b0, 1'b0);
            e4 = exp_q.pop_front(); ew = exp_w_q.pop_front();
            checks += 4;
            if (obs_n() !== e4) begin fails++; $display("FAIL match_sb4 step %0d: got %h, required %h", i, obs_n(), e4); end
            if (obs_w() !== ew) begin fails++; $display("FAIL match_sbw step %0d: got %h, required %h", i, obs_w(), ew); end
            if (match4 !== em[i]) begin fails++; $display("FAIL match_pulse step %0d: got %b, required %b", i, match4, em[i]); end
            if (cnt4 !== ec[i])   begin fails++; $display("FAIL match_cnt step %0d: got %0d, required %0d", i, cnt4, ec[i]); end
        end
    endtask

    task automatic test_saturation();
        logic [27:0] e4;
        logic [50:0] ew;
        logic       c   [7] = '{1, 0, 0, 0, 0, 0, 1};
        logic [1:0] ec2 [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        logic [7:0] ec  [7] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
        for (int i = 0; i < 7; i++) begin
            drive(MODE_HOLD, 1'b0, 16'h0, c[i], 1'b0);
            e4 = exp_q.pop_front(); ew = exp_w_q.pop_front();
            checks += 5;
            if (obs_n() !== e4) begin fails++; $display("FAIL sat_sb4 step %0d: got %h, required %h", i, obs_n(), e4); end
            if (obs_w() !== ew) begin fails++; $display("FAIL sat_sbw step %0d: got %h, required %h", i, obs_w(), ew); end
            if (cnt4s !== ec2[i]) begin fails++; $display("FAIL sat_cnt2 step %0d: got %0d, required %0d", i, cnt4s, ec2[i]); end
            if (cnt4 !== ec[i])   begin fails++; $display("FAIL sat_cnt8 step %0d: got %0d, required %0d", i, cnt4, ec[i]); end
            if (match4s !== 1'b1) begin fails++; $display("FAIL sat_match step %0d: got %b, required 1", i, match4s); end
        end
    endtask

    task automatic test_equal_bits();
        logic [27:0] e4;
        logic [50:0] ew;
        logic [1:0] md [3] = '{MODE_LOAD, MODE_SHL, MODE_SHR};
        logic [3:0] eq [3] = '{4'b1001, 4'b0011, 4'b1001};
        pat[0] = 16'h000F;
        for (int i = 0; i < 3; i++) begin
            drive(md[i], 1'b1, 16'h0009, 1'b0, 1'b0);
            e4 = exp_q.pop_front(); ew = exp_w_q.pop_front();
            checks += 4;
            if (obs_n() !== e4) begin fails++; $display("FAIL equal_sb4 step %0d: got %h, required %h", i, obs_n(), e4); end
            if (obs_w() !== ew) begin fails++; $display("FAIL equal_sbw step %0d: got %h, required %h", i, obs_w(), ew); end
            if (q4 !== eq[i])   begin fails++; $display("FAIL equal_q step %0d: got %b, required %b", i, q4, eq[i]); end
            if (ones4 !== 3'd2) begin fails++; $display("FAIL equal_ones step %0d: got %0d, required 2", i, ones4); end
        end
    endtask

    task automatic test_reset_mid();
        logic [27:0] e4;
        logic [50:0] ew;
        logic [1:0] md [3] = '{MODE_LOAD, MODE_SHL, MODE_SHL};
        logic       rs [3] = '{0, 1, 0};
        logic [3:0] eq [3] = '{4'b1111, 4'b0000, 4'b0001};
        logic       em [3] = '{1, 0, 0};
        logic [2:0] eo [3] = '{3'd4, 3'd0, 3'd1};
        pat[0] = 16'h000F;
        for (int i = 0; i < 3; i++) begin
            drive(md[i], 1'b1, 16'hFFFF, 1'b0, rs[i]);
            e4 = exp_q.pop_front(); ew = exp_w_q.pop_front();
            checks += 5;
            if (obs_n() !== e4) begin fails++; $display("FAIL rstmid_sb4 step %0d: got %h, required %h", i, obs_n(), e4); end
            if (obs_w() !== ew) begin fails++; $display("FAIL rstmid_sbw step %0d: got %h, required %h", i, obs_w(), ew); end
            if (q4 !== eq[i])     begin fails++; $display("FAIL rstmid_q step %0d: got %b, required %b", i, q4, eq[i]); end
            if (match4 !== em[i]) begin fails++; $display("FAIL rstmid_match step %0d: got %b, required %b", i, match4, em[i]); end
            if (ones4 !== eo[i])  begin fails++; $display("FAIL rstmid_ones step %0d: got %0d, required %0d", i, ones4, eo[i]); end
        end
        checks += 1;
        if (cnt4 !== 8'd0) begin fails++; $display("FAIL rstmid_cnt: got %0d, required 0", cnt4); end
    endtask

    task automatic test_random();
        logic [27:0] e4;
        logic [50:0] ew;
        for (int i = 0; i < 10000; i++) begin
            if (i % 8 == 0) begin
                pat[0] = 16'($urandom_range(0, 15));
                pat[1] = 16'($urandom_range(0, 127));
                pat[2] = 16'($urandom_range(0, 65535));
            end
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 65535)), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 499) == 0));
            e4 = exp_q.pop_front(); ew = exp_w_q.pop_front();
            checks += 2;
            if (obs_n() !== e4) begin fails++; $display("FAIL random_sb4 cycle %0d: got %h, required %h", i, obs_n(), e4); end
            if (obs_w() !== ew) begin fails++; $display("FAIL random_sbw cycle %0d: got %h, required %h", i, obs_w(), ew); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0; fails = 0;
        rst = 1'b1; in_b = 1'b0; mode = MODE_HOLD; ld16 = 16'h0; clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pat[k] = 16'h0; m_q[k] = 16'h0; m_match[k] = 1'b0; m_cnt[k] = 0;
        end
        m_cnt2 = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_shl();
        test_load_shr();
        test_match();
        test_saturation();
        test_equal_bits();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
